// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared I2S definitions: transmit sequencer state encoding and
//               slot/frame geometry of the I2S2 Pmod clock generator.
//               Intended to be shared with a future receive sequencer.
// Contents    : tx_state_t  - IDLE / WAIT_FRAME / LEFT / RIGHT
//               SlotBits    - sclk periods per channel slot
//               FrameBits   - sclk periods per stereo frame
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      LEFT       = 2'd2,
      RIGHT      = 2'd3
   } tx_state_t;

   localparam int SlotBits  = 32;
   localparam int FrameBits = 64;

endpackage
`default_nettype wire

// File: rtl/i2s_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_sequencer_if
// Description : Signal bundle between the audio datapath / clock generator
//               and the I2S transmit sequencer.
// Ports       : enable      - run request
//               sclk, lrck  - bit / word clock (clk-domain registers)
//               sampleLeft, sampleRight, sampleValid, sampleReady
//                           - stereo sample handshake
//               sdout       - serial data to the DAC
//               underflow   - frame started with an empty buffer
//               active      - sequencer is streaming
//               master : drives the inputs of the sequencer
//               slave  : the sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_sequencer_if #(
   parameter int DataWidth = 24
) ();

   logic                 enable;
   logic                 sclk;
   logic                 lrck;
   logic [DataWidth-1:0] sampleLeft;
   logic [DataWidth-1:0] sampleRight;
   logic                 sampleValid;
   logic                 sampleReady;
   logic                 sdout;
   logic                 underflow;
   logic                 active;

   modport master (
      output enable, sclk, lrck, sampleLeft, sampleRight, sampleValid,
      input  sampleReady, sdout, underflow, active
   );

   modport slave (
      input  enable, sclk, lrck, sampleLeft, sampleRight, sampleValid,
      output sampleReady, sdout, underflow, active
   );

endinterface
`default_nettype wire

// File: rtl/i2s_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : i2s_edge_detect
// Description : Registers sclk/lrck and flags their edges in the clk domain.
//               During reset the registers track the live inputs so that no
//               false edge appears on reset release.
// Ports       : clk, reset  - system clock, synchronous active-low reset
//               sclk_i      - bit clock
//               lrck_i      - word clock
//               sclkFall_o  - sclk went 1 -> 0
//               lrckFall_o  - lrck went 1 -> 0 (start of left slot)
//               lrckRise_o  - lrck went 0 -> 1 (start of right slot)
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sclk_i,
   input  logic lrck_i,
   output logic sclkFall_o,
   output logic lrckFall_o,
   output logic lrckRise_o
);

   logic sclk_q;
   logic lrck_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sclk_q <= sclk_i;
         lrck_q <= lrck_i;
      end else begin
         sclk_q <= sclk_i;
         lrck_q <= lrck_i;
      end
   end

   assign sclkFall_o = sclk_q & ~sclk_i;
   assign lrckFall_o = lrck_q & ~lrck_i;
   assign lrckRise_o = ~lrck_q & lrck_i;

endmodule
`default_nettype wire

// File: rtl/i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_sequencer
// Description : I2S transmit sequencer. Accepts one stereo pair per frame via
//               valid/ready into a one-entry holding buffer and serialises it
//               MSB first, one sclk after each lrck edge, lrck low = left.
// Ports       : clk, reset   - system clock, synchronous active-low reset
//               bus (slave)  - enable, sclk, lrck, sample handshake, sdout,
//                              underflow pulse, active status
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_sequencer
   import i2s_pkg::*;
#(
   parameter int DataWidth = 24,
   parameter int SlotBits  = i2s_pkg::SlotBits
) (
   input  logic              clk,
   input  logic              reset,
   i2s_tx_sequencer_if.slave bus
);

   logic                 sclkFall;
   logic                 lrckFall;
   logic                 lrckRise;

   tx_state_t            state_q,      state_d;
   logic                 bufFull_q,    bufFull_d;
   logic [DataWidth-1:0] bufL_q,       bufL_d;
   logic [DataWidth-1:0] bufR_q,       bufR_d;
   logic [SlotBits-1:0]  shift_q,      shift_d;
   logic [SlotBits-1:0]  rightStage_q, rightStage_d;
   logic                 sdout_q,      sdout_d;
   logic                 underflow_q,  underflow_d;

   logic                 sampleReady;
   logic                 handshake;
   logic [DataWidth-1:0] loadL;
   logic [DataWidth-1:0] loadR;
   logic                 loadEmpty;
   logic [SlotBits-1:0]  padL;
   logic [SlotBits-1:0]  padR;

   i2s_edge_detect u_edge (
      .clk        (clk),
      .reset      (reset),
      .sclk_i     (bus.sclk),
      .lrck_i     (bus.lrck),
      .sclkFall_o (sclkFall),
      .lrckFall_o (lrckFall),
      .lrckRise_o (lrckRise)
   );

   assign sampleReady = !bufFull_q && (state_q != IDLE);
   assign handshake   = bus.sampleValid && sampleReady;

   // Frame source: a pair accepted in this very cycle wins (bypass), then the
   // holding buffer, otherwise silence with an underflow pulse.
   always_comb begin
      loadL     = '0;
      loadR     = '0;
      loadEmpty = 1'b1;
      if (handshake) begin
         loadL     = bus.sampleLeft;
         loadR     = bus.sampleRight;
         loadEmpty = 1'b0;
      end else if (bufFull_q) begin
         loadL     = bufL_q;
         loadR     = bufR_q;
         loadEmpty = 1'b0;
      end
   end

   // Left-justify the sample in its slot; low bits are zero padding.
   assign padL = SlotBits'(loadL) << (SlotBits - DataWidth);
   assign padR = SlotBits'(loadR) << (SlotBits - DataWidth);

   always_comb begin
      state_d      = state_q;
      bufFull_d    = bufFull_q;
      bufL_d       = bufL_q;
      bufR_d       = bufR_q;
      shift_d      = shift_q;
      rightStage_d = rightStage_q;
      sdout_d      = sdout_q;
      underflow_d  = 1'b0;

      if (handshake) begin
         bufFull_d = 1'b1;
         bufL_d    = bus.sampleLeft;
         bufR_d    = bus.sampleRight;
      end

      case (state_q)
         IDLE: begin
            sdout_d = 1'b0;
            if (bus.enable) state_d = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            // The bit emitted on the entering lrck fall belongs to no frame.
            sdout_d = 1'b0;
            if (lrckFall) begin
               state_d      = LEFT;
               shift_d      = padL;
               rightStage_d = padR;
               bufFull_d    = 1'b0;
               underflow_d  = loadEmpty;
            end
         end
         LEFT: begin
            // On the lrck edge sdout still takes the outgoing slot's last bit;
            // this yields the one-sclk I2S data delay.
            if (sclkFall) sdout_d = shift_q[SlotBits-1];
            if (lrckRise) begin
               state_d = RIGHT;
               shift_d = rightStage_q;
            end else if (sclkFall) begin
               shift_d = {shift_q[SlotBits-2:0], 1'b0};
            end
         end
         RIGHT: begin
            if (sclkFall) sdout_d = shift_q[SlotBits-1];
            if (lrckFall) begin
               state_d      = LEFT;
               shift_d      = padL;
               rightStage_d = padR;
               bufFull_d    = 1'b0;
               underflow_d  = loadEmpty;
            end else if (sclkFall) begin
               shift_d = {shift_q[SlotBits-2:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase

      if (!bus.enable) begin
         state_d     = IDLE;
         sdout_d     = 1'b0;
         bufFull_d   = 1'b0;
         underflow_d = 1'b0;
         shift_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         bufFull_q    <= 1'b0;
         bufL_q       <= '0;
         bufR_q       <= '0;
         shift_q      <= '0;
         rightStage_q <= '0;
         sdout_q      <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bufFull_q    <= bufFull_d;
         bufL_q       <= bufL_d;
         bufR_q       <= bufR_d;
         shift_q      <= shift_d;
         rightStage_q <= rightStage_d;
         sdout_q      <= sdout_d;
         underflow_q  <= underflow_d;
      end
   end

   assign bus.sampleReady = sampleReady;
   assign bus.sdout       = sdout_q;
   assign bus.underflow   = underflow_q;
   assign bus.active      = (state_q == LEFT) || (state_q == RIGHT);

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_sequencer
// Description : Self-checking bench for i2s_tx_sequencer. A clk-domain clock
//               generator model (sclk = 8 clk, frame = 512 clk) drives
//               sclk/lrck; a frame-level reference model predicts the
//               handshake, underflow and the 64 bits of every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_sequencer;

   localparam int DW       = 24;
   localparam int M_OFF    = 0;   // disabled or in reset
   localparam int M_ARMED  = 1;   // enabled, waiting for a frame start
   localparam int M_STREAM = 2;   // frames are being transmitted

   logic       clk;
   logic       reset;
   logic [8:0] cnt;

   i2s_tx_sequencer_if #(.DataWidth(DW)) bus ();

   i2s_tx_sequencer #(.DataWidth(DW), .SlotBits(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic        chk;
      logic [63:0] bits;
   } exp_t;

   exp_t    expQ[$];
   int      nChecks = 0;
   int      nFail   = 0;
   int      accCount = 0;
   logic    expReady, expActive, expUnder;
   int      mMode;
   logic    mFull;
   logic [DW-1:0] mL, mR;
   logic    mPrevL;

   // Expected frame: each channel left-justified in a 32-bit slot.
   function automatic logic [63:0] frameOf(input logic [DW-1:0] l, input logic [DW-1:0] r);
      return (64'(l) << (64 - DW)) | (64'(r) << (32 - DW));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      nChecks++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic markLastUnchecked();
      exp_t t;
      if (expQ.size() > 0) begin
         t     = expQ.pop_back();
         t.chk = 1'b0;
         expQ.push_back(t);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Clock generator model: registered counter, sclk = bit 2, lrck = bit 8.
   initial begin
      cnt      = '0;
      bus.sclk = 1'b0;
      bus.lrck = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cnt      = cnt + 9'd1;
         bus.sclk = cnt[2];
         bus.lrck = cnt[8];
      end
   end

   // Reference model: one frame-start decision per lrck fall.
   initial begin
      logic fall, ready, acc;
      mMode     = M_OFF;
      mFull     = 1'b0;
      mL        = '0;
      mR        = '0;
      mPrevL    = 1'b0;
      expReady  = 1'b0;
      expActive = 1'b0;
      expUnder  = 1'b0;
      forever begin
         @(posedge clk);
         fall     = mPrevL && !bus.lrck;
         mPrevL   = bus.lrck;
         expUnder = 1'b0;
         if (!reset) begin
            markLastUnchecked();
            if (fall) expQ.push_back(exp_t'({1'b0, 64'd0}));
            mMode = M_OFF;
            mFull = 1'b0;
         end else if (!bus.enable) begin
            if (mMode == M_STREAM) markLastUnchecked();
            if (fall) expQ.push_back(exp_t'({1'b1, 64'd0}));
            mMode = M_OFF;
            mFull = 1'b0;
         end else begin
            ready = (mMode != M_OFF) && !mFull;
            acc   = bus.sampleValid && ready;
            if (acc) accCount++;
            if (mMode == M_OFF) begin
               mMode = M_ARMED;
               if (fall) expQ.push_back(exp_t'({1'b1, 64'd0}));
            end else if (fall) begin
               mMode = M_STREAM;
               if (acc) begin
                  expQ.push_back(exp_t'({1'b1, frameOf(bus.sampleLeft, bus.sampleRight)}));
               end else if (mFull) begin
                  expQ.push_back(exp_t'({1'b1, frameOf(mL, mR)}));
                  mFull = 1'b0;
               end else begin
                  expQ.push_back(exp_t'({1'b1, 64'd0}));
                  expUnder = 1'b1;
               end
            end else if (acc) begin
               mFull = 1'b1;
               mL    = bus.sampleLeft;
               mR    = bus.sampleRight;
            end
         end
         expReady  = (mMode != M_OFF) && !mFull;
         expActive = (mMode == M_STREAM);
      end
   end

   // Monitor: per-cycle status checks plus one 64-bit frame compare per frame,
   // sampling sdout at each sclk rise like the DAC does.
   initial begin
      logic [63:0] monBits;
      logic        monPrevSclk;
      exp_t        e;
      monBits     = '0;
      monPrevSclk = 1'b0;
      forever begin
         @(negedge clk);
         check("sampleReady", 64'(bus.sampleReady), 64'(expReady));
         check("active",      64'(bus.active),      64'(expActive));
         check("underflow",   64'(bus.underflow),   64'(expUnder));
         if (!expActive) check("sdout_quiet", 64'(bus.sdout), 64'(0));
         if (bus.sclk && !monPrevSclk) begin
            monBits = {monBits[62:0], bus.sdout};
            // Rise 0 after lrck fall carries the last bit of the previous frame.
            if (cnt[8:3] == 6'd0 && expQ.size() >= 2) begin
               e = expQ.pop_front();
               if (e.chk) check("frame_bits", monBits, e.bits);
            end
         end
         monPrevSclk = bus.sclk;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input int cycles, input int pct);
      repeat (cycles) begin
         step();
         bus.sampleValid = ($urandom_range(0, 99) < pct);
         bus.sampleLeft  = DW'($urandom);
         bus.sampleRight = DW'($urandom);
      end
   endtask

   task automatic waitAccept();
      int start;
      int budget;
      start  = accCount;
      budget = 0;
      while (accCount == start && budget < 2000) begin
         step();
         budget++;
      end
      nChecks++;
      if (accCount == start) begin
         nFail++;
         $display("FAIL accept_timeout: actual=none required=accept");
      end
      bus.sampleValid = 1'b0;
   endtask

   task automatic waitCnt(input logic [8:0] v);
      int budget;
      budget = 0;
      step();
      while (cnt != v && budget < 1100) begin
         step();
         budget++;
      end
      nChecks++;
      if (cnt != v) begin
         nFail++;
         $display("FAIL cnt_timeout: actual=%0d required=%0d", cnt, v);
      end
   endtask

   initial begin
      reset           = 1'b0;
      bus.enable      = 1'b0;
      bus.sampleValid = 1'b0;
      bus.sampleLeft  = '0;
      bus.sampleRight = '0;
      repeat (5) step();
      reset = 1'b1;

      // Basic frame offered before the first lrck fall.
      bus.enable      = 1'b1;
      bus.sampleValid = 1'b1;
      bus.sampleLeft  = 24'hA5_0F3C;
      bus.sampleRight = 24'h80_0001;
      waitAccept();

      // Starvation, then a single pair.
      drive(3 * 512, 0);
      bus.sampleValid = 1'b1;
      bus.sampleLeft  = DW'($urandom);
      bus.sampleRight = DW'($urandom);
      waitAccept();

      // Sparse random traffic, then continuous backpressure.
      drive(6 * 512, 3);
      drive(4 * 512, 100);
      drive(512, 0);

      // Bypass: offer exactly on the lrck-fall cycle with an empty buffer.
      repeat (2) begin
         bus.sampleValid = 1'b0;
         waitCnt(9'd0);
         bus.sampleValid = 1'b1;
         bus.sampleLeft  = DW'($urandom);
         bus.sampleRight = DW'($urandom);
         step();
         bus.sampleValid = 1'b0;
         drive(1024, 0);
      end

      // Enable drop in the middle of the right slot.
      drive(512, 3);
      bus.sampleValid = 1'b0;
      waitCnt(9'd300);
      bus.enable = 1'b0;
      drive(20, 3);
      bus.enable = 1'b1;
      drive(3 * 512, 3);

      // Reset pulse in the middle of the left slot.
      bus.sampleValid = 1'b0;
      waitCnt(9'd100);
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      drive(3 * 512, 3);

      bus.sampleValid = 1'b0;
      drive(2 * 512 + 10, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2s_tx_sequencer.md
Name: i2s_tx_sequencer

Overview:
Transmit-side sequencer for the I2S2 Pmod DAC path. It watches the sclk and lrck outputs of the I2S clock generator, which are in the same clk domain. It accepts one stereo sample per frame through a valid/ready handshake and serialises it onto sdout in standard I2S format: MSB first, one sclk delay after each lrck edge, lrck low selects left. It sits between the audio datapath and the Pmod pins, alongside the clock generator.

Parameters:
- DataWidth, 24, bits per channel sample; legal range 1..32; left-justified in a 32-bit slot and zero-padded.
- SlotBits, 32, sclk periods per channel (lrck half-period). Fixed by the clock generator ratio; not meant to be overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- enable  in  1  run request; 0 forces IDLE
- sclk  in  1  bit clock from the clock generator (clk-domain register)
- lrck  in  1  word clock from the clock generator (clk-domain register)
- sampleLeft  in  DataWidth  left sample, two's complement
- sampleRight  in  DataWidth  right sample
- sampleValid  in  1  sample pair offered
- sampleReady  out  1  holding buffer empty, pair will be accepted
- sdout  out  1  serial data to the DAC
- underflow  out  1  one-clk pulse: frame started with an empty buffer
- active  out  1  high in LEFT or RIGHT state

Behaviour:
- Reset (reset==0 at posedge clk):
  - sdout=0, sampleReady=0, underflow=0, active=0.
  - Holding buffer is emptied. Shift register=0. State=IDLE. Edge-detect registers are loaded with the current sclk/lrck values, so no false edge is seen on release.
- Edge detection:
  - Registered copies sclkQ and lrckQ.
  - sclkFall = sclkQ & ~sclk.
  - lrckFall = lrckQ & ~lrck (start of left).
  - lrckRise = ~lrckQ & lrck (start of right).
  - lrck edges always coincide with an sclk fall.
- Holding buffer (one entry, left+right):
  - sampleReady = buffer empty && state != IDLE.
  - Transfer on sampleValid && sampleReady at posedge clk. sampleReady drops the next cycle.
- States:
  - IDLE: sdout=0. Go to WAIT_FRAME when enable==1.
  - WAIT_FRAME: sampleReady may be high. Go to LEFT on lrckFall.
  - LEFT: go to RIGHT on lrckRise.
  - RIGHT: go to LEFT on lrckFall.
  - Any state: enable==0 goes to IDLE next cycle, sdout=0, buffer emptied.
- Frame load (on lrckFall in WAIT_FRAME or RIGHT):
  - If the buffer is full: shift register gets {sampleLeft_buf, zero pad}, right staging gets sampleRight_buf, buffer is emptied.
  - If the buffer is empty: load zeros for both channels and pulse underflow for 1 clk.
  - If a handshake fires in the same cycle as lrckFall, the accepted pair is used immediately, with no underflow. This is a bypass.
- On lrckRise: shift register gets {right staging, zero pad}.
- Serialisation:
  - On every sclkFall in LEFT/RIGHT: sdout gets shiftReg[31]. On non-lrck falls, shiftReg also shifts left by 1 with zero fill.
  - On an lrck edge, sdout takes the old shiftReg[31] (the last slot bit, 0) before the reload.
  - Result: the MSB appears on the second sclk fall of the slot, giving the I2S one-bit delay.
  - sdout lags the detected sclk fall by 1 clk and is stable across the DAC's rising-edge sample point.
- The first frame after WAIT_FRAME: the sdout bit at the entering lrckFall is 0.

Decomposition:
- Package i2s_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT_FRAME, LEFT, RIGHT} tx_state_t.
  - localparam SlotBits = 32, FrameBits = 64.
  - Shared with a future receive sequencer.
- One sub-module: i2s_edge_detect, which registers sclk/lrck and produces sclkFall/lrckFall/lrckRise. The rx path will reuse it.
- Everything else stays in i2s_tx_sequencer.

Test Plan:
- Bench setup: clock generator clockConfig=0, so sclk period is 8 clk and the frame is 512 clk.
- Basic frame: offer L=24'hA5_0F3C, R=24'h80_0001 before the first lrckFall -> sdout bits sampled at sclk rise, slot bit 1..24 = L MSB-first, bits 25..32 = 0; right slot = R likewise; underflow stays 0.
- Underflow: enable with no sampleValid -> one underflow pulse per frame, sdout constant 0 for 64 sclk; next offered pair lands in the following frame.
- Backpressure: sampleValid held high with changing data every clk -> exactly one accepted pair per frame; sampleReady high only between its frame load and the next accept.
- Bypass: handshake asserted exactly on the lrckFall cycle -> that pair transmitted in the same frame, no underflow.
- enable drop mid-right slot -> IDLE next clk, sdout=0, sampleReady=0; re-enable -> waits for the next lrckFall, first frame correct.
- reset low mid-frame for 3 clk -> all outputs 0 immediately; no spurious edge or underflow after release; resumes at the next lrckFall.
